fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch front end feeding the decode stage. Issues in-order word requests to instruction
//  memory, buffers returned words with their PC in a small prefetch FIFO, presents them to decode over a
//  valid/ready handshake, and handles branch/jump redirects by flushing the FIFO and dropping stale responses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  4              prefetch entries; power of two, >= 2; also the cap on outstanding live requests
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   asynchronous active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   response valid; in order, at most one per cycle, no backpressure
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   branch/jump taken; flush and refetch
//  redirect_pc     in   32  new PC; bits [1:0] ignored, forced to 0
//  instr_valid     out  1   FIFO head valid
//  instr_ready     in   1   decode consumes head
//  instr           out  32  head instruction word
//  instr_pc        out  32  PC of head instruction
// BEHAVIOUR
//  - Reset (async, rst_n low): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, live_cnt=drop_cnt=0;
//    imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0. Requesting starts the first cycle after release.
//  - Credit: imem_req_valid = (live_cnt + fifo_count < FIFO_DEPTH) & ~redirect_valid & (drop_cnt < FIFO_DEPTH).
//    imem_req_addr = fetch_pc. Accept (valid&ready): fetch_pc += 4 (wraps mod 2^32), live_cnt++.
//  - While valid and not accepted, addr held stable. Redirect gates valid low, so no acceptance in redirect cycle.
//  - Response: if drop_cnt>0 -> discard, drop_cnt--. Else push {rsp_pc, data}, rsp_pc += 4, live_cnt--.
//    Push can never overflow (credit rule). Push visible on instr_valid next cycle (1-cycle min latency, no bypass).
//  - Pop on instr_valid & instr_ready; simultaneous push+pop on full/any FIFO allowed, count unchanged.
//  - Redirect (registered, takes effect next cycle): FIFO cleared; fetch_pc=rsp_pc=redirect_pc&~3;
//    drop_cnt = drop_cnt + live_cnt - (1 if a non-dropped response arrives this cycle) - (1 if dropped one
//    arrives); live_cnt=0. A pop in the redirect cycle completes normally (decode has taken it); all other
//    entries, including a response arriving that cycle, are discarded.
//  - Back-to-back redirects: each recomputes drop_cnt from the current counts; last one wins.
//  - Counters are clog2(FIFO_DEPTH)+1 bits; drop_cnt + live_cnt <= 2*FIFO_DEPTH by construction.
//  - Reset mid-operation: all state cleared immediately; memory responses to pre-reset requests
//    must not arrive after reset release (memory is reset from the same rst_n).
// CONFIGURATION
//  FETCH_ILLEGAL_EN defined: extra output port instr_illegal (out, 1) = instr_valid & (instr[1:0] != 2'b11),
//    flags non-32-bit encodings (decode ignores bits [1:0]); stored per FIFO entry, reset value 0.
//  Not defined: port and logic absent; bits [1:0] passed through unchecked.
// TESTING
//  1 RESET_PC=0x100, ready=1, rsp latency 1, instr_ready=1 -> addrs 0x100,0x104,0x108..; instr_pc matches, data in order.
//  2 instr_ready=0, latency 1 -> exactly 4 accepted requests then imem_req_valid=0; release -> resumes, no loss/dup.
//  3 latency 3, 3 outstanding, redirect_pc=0x203 -> 3 responses dropped; first instr_pc=0x200, next req addr 0x200.
//  4 redirect same cycle as instr handshake and arriving response -> popped entry consumed, response dropped, FIFO empty.
//  5 imem_req_ready=0 for 5 cycles -> imem_req_addr stable, imem_req_valid held, fetch_pc unchanged.
//  6 rst_n low mid-stream (async, off clock edge) -> outputs 0 immediately; restart at RESET_PC.
//  7 FETCH_ILLEGAL_EN: data 0x00000013 -> instr_illegal=0; 0x00000010 -> 1.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with prefetch FIFO and redirect handling
//
// Issues in-order word fetches to instruction memory, buffers returned words
// together with their PC, and hands them to decode over a valid/ready handshake.
// A redirect flushes the FIFO and arranges for responses to stale requests to be dropped.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      fetch request channel (word-aligned address)
//   imem_rsp_valid/data            in-order response channel, no backpressure
//   redirect_valid/pc              taken branch/jump, new PC (bits [1:0] ignored)
//   instr_valid/ready, instr,      FIFO head presented to decode
//   instr_pc
//   instr_illegal                  only with FETCH_ILLEGAL_EN: head is not a 32-bit encoding
//
// Build option: define FETCH_ILLEGAL_EN to add the instr_illegal output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_ILLEGAL_EN
  ,
  output logic        instr_illegal
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic          started_q;

  logic [31:0]   mem_data_q [FIFO_DEPTH];
  logic [31:0]   mem_pc_q   [FIFO_DEPTH];
`ifdef FETCH_ILLEGAL_EN
  logic          mem_ill_q  [FIFO_DEPTH];
`endif

  logic          req_fire, rsp_drop, rsp_keep, push, pop;
  logic [CW:0]   credit_sum;
  logic [CW:0]   drop_sum;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Live requests plus buffered entries never exceed the FIFO size, so a
  // response always has a slot; drop_cnt cap keeps the counters in range.
  assign credit_sum     = {1'b0, live_q} + {1'b0, cnt_q};
  assign imem_req_valid = started_q & (credit_sum < DEPTH_W) & ~redirect_valid
                        & ({1'b0, drop_q} < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire    = imem_req_valid & imem_req_ready;
  assign rsp_drop    = imem_rsp_valid & (drop_q != '0);
  assign rsp_keep    = imem_rsp_valid & (drop_q == '0);
  assign instr_valid = (cnt_q != '0);
  assign pop         = instr_valid & instr_ready;
  assign push        = rsp_keep & ~redirect_valid;

  // Every live request, plus any already owed drop, becomes a drop; the
  // response arriving this cycle (kept or dropped) retires one of them.
  assign drop_sum = {1'b0, drop_q} + {1'b0, live_q} - (CW+1)'(imem_rsp_valid);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    live_d     = live_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      live_d     = '0;
      drop_d     = drop_sum[CW-1:0];
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)     rsp_pc_d   = rsp_pc_q + 32'd4;
      live_d = live_q + CW'(req_fire) - CW'(rsp_keep);
      drop_d = drop_q - CW'(rsp_drop);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      live_q     <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      started_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_pc_q[i]   <= '0;
`ifdef FETCH_ILLEGAL_EN
        mem_ill_q[i]  <= 1'b0;
`endif
      end
    end else if (push) begin
      mem_data_q[wr_q] <= imem_rsp_data;
      mem_pc_q[wr_q]   <= rsp_pc_q;
`ifdef FETCH_ILLEGAL_EN
      mem_ill_q[wr_q]  <= (imem_rsp_data[1:0] != 2'b11);
`endif
    end
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  assign instr    = instr_valid ? mem_data_q[rd_q] : '0;
  assign instr_pc = instr_valid ? mem_pc_q[rd_q]   : '0;
`ifdef FETCH_ILLEGAL_EN
  assign instr_illegal = instr_valid & mem_ill_q[rd_q];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_ILLEGAL_EN
  logic        instr_illegal;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_ILLEGAL_EN
    , .instr_illegal(instr_illegal)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Memory contents: low byte 0x13 (32-bit encoding) or 0x10 when addr bit 3 is set.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], (a[3] ? 8'h10 : 8'h13)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: responses driven at negedge+1, requests sampled at negedge+2.
  int          lat = 1;
  int          cyc = 0;
  int          acc_cnt = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];

  always @(negedge clk) begin
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (!rst_n) begin
      q_addr.delete();
      q_due.delete();
    end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    #1;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cyc + lat);
      acc_cnt++;
    end
  end

  // Scoreboard monitor.
  logic [31:0] sb_pc[$];
  logic [31:0] sb_data[$];
  logic [31:0] epc, edat;

  always @(negedge clk) begin
    #2;
    if (rst_n && instr_valid && instr_ready) begin
      if (sb_pc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h, expected no instruction", instr_pc);
      end else begin
        epc  = sb_pc.pop_front();
        edat = sb_data.pop_front();
        chk("instr_pc", instr_pc, epc);
        chk("instr", instr, edat);
`ifdef FETCH_ILLEGAL_EN
        chk("instr_illegal", {31'b0, instr_illegal}, {31'b0, (edat[1:0] != 2'b11)});
`endif
      end
    end
  end

  logic [31:0] nxt;

  task automatic expect_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      sb_pc.push_back(start + 32'(4 * i));
      sb_data.push_back(mem_word(start + 32'(4 * i)));
    end
    nxt = start + 32'(4 * n);
    @(negedge clk);
    instr_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb_pc.size() == 0) break;
    end
    if (sb_pc.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: %0d entries left, expected 0", sb_pc.size());
      sb_pc.delete();
      sb_data.delete();
    end
    instr_ready = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
`ifdef FETCH_ILLEGAL_EN
    chk({tag, "_instr_illegal"}, {31'b0, instr_illegal}, 32'd0);
`endif
  endtask

  int a0;

  initial begin
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode stalled: exactly FIFO_DEPTH requests then the credit runs out.
    repeat (12) @(negedge clk);
    #3;
    chk("stall_accepts", 32'(acc_cnt), 32'd4);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_instr_valid", {31'b0, instr_valid}, 32'd1);

    // Streaming from RESET_PC, including the four buffered words.
    expect_run(RST_PC, 12);

    // Latency 3, three outstanding, redirect to an unaligned target.
    repeat (6) @(negedge clk);
    imem_req_ready = 1'b0;
    expect_run(nxt, 4);
    lat = 3;
    repeat (3) @(negedge clk);
    a0 = acc_cnt;
    imem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    #3;
    chk("redir_outstanding", 32'(acc_cnt - a0), 32'd3);
    chk("redir_req_gated", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #3;
    chk("redir_next_addr", imem_req_addr, 32'h0000_0200);
    chk("redir_next_valid", {31'b0, imem_req_valid}, 32'd1);
    expect_run(32'h0000_0200, 6);
    lat = 1;

    // Memory not ready: request held with a stable address.
    repeat (8) @(negedge clk);
    imem_req_ready = 1'b0;
    expect_run(nxt, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      chk("hold_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("hold_addr", imem_req_addr, nxt);
    end
    @(negedge clk);
    imem_req_ready = 1'b1;
    expect_run(nxt, 4);

    // Redirect coincident with a pop and an arriving response.
    repeat (6) @(negedge clk);
    sb_pc.push_back(nxt);
    sb_data.push_back(mem_word(nxt));
    sb_pc.push_back(nxt + 32'd4);
    sb_data.push_back(mem_word(nxt + 32'd4));
    @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    @(negedge clk);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0302;
    @(negedge clk);
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    #3;
    chk("flush_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("flush_popped_both", 32'(sb_pc.size()), 32'd0);
    sb_pc.delete();
    sb_data.delete();
    expect_run(32'h0000_0300, 4);

    // Asynchronous reset in the middle of a cycle.
    repeat (6) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_run(RST_PC, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
